conv_result_serializer: RTL and testbench
=========================================

// Module: conv_result_serializer
// PURPOSE
//  Downstream stage of the 8x8-tap linear convolver. Captures one full 15-sample
//  result frame y[0..14] in a single cycle and streams it out one sample per beat,
//  oldest index first, over a valid/ready interface. It is the bridge between the
//  parallel convolver output and narrow serial consumers (UART/FIFO/checker).
// PARAMETERS
//  DATA_W   4   bits per result sample (matches convolver output width)
//  N_OUT   15   samples per frame (2*8-1)
//  IDX_W    4   width of out_idx; must satisfy 2**IDX_W >= N_OUT
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              asynchronous active-low reset
//  in_valid    in   1              y_in holds a complete frame
//  in_ready    out  1              serializer can accept a frame
//  y_in        in   N_OUT*DATA_W   flattened frame; y[n] = y_in[n*DATA_W +: DATA_W]
//  out_valid   out  1              out_data/out_idx are valid
//  out_ready   in   1              consumer accepts current beat
//  out_data    out  DATA_W         current sample
//  out_idx     out  IDX_W          index n of current sample
//  out_last    out  1              current beat is the final beat of the frame
//  frames_done out  8              count of completed frames, wraps 255->0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, buffer=0, idx=0, out_valid=0, out_data=0,
//    out_idx=0, out_last=0, frames_done=0; in_ready=1 as soon as rst_n deasserts.
//  - FSM: IDLE -> STREAM on load; STREAM -> IDLE on final beat accept
//    (with CONV_SER_CHECKSUM_EN: STREAM -> CSUM -> IDLE).
//  - in_ready = (state==IDLE). Load = in_valid & in_ready: all N_OUT samples
//    registered in that cycle, idx<=0. in_valid while busy is ignored (no capture).
//  - Latency: out_valid rises the cycle after load; first beat is y[0].
//  - STREAM: out_valid=1, out_data=buf[idx], out_idx=idx. Beat = out_valid & out_ready.
//    On beat idx<=idx+1. out_data/out_idx held stable while out_ready=0 (no drop).
//  - out_last=1 only while presenting the final beat (idx==N_OUT-1 without macro).
//  - Final beat accepted: state<=IDLE, frames_done<=frames_done+1 (mod 256),
//    out_valid falls next cycle. One IDLE bubble minimum between frames: a new load
//    cannot coincide with the final beat.
//  - IDLE: out_valid=0, out_data=0, out_idx=0, out_last=0.
//  - No arithmetic on samples; values pass bit-exact. out_data=0 when out_valid=0.
//  - Reset mid-frame: frame abandoned, outputs to reset values, frames_done=0.
// CONFIGURATION
//  CONV_SER_CHECKSUM_EN defined: at load also register csum = sum of all N_OUT
//    samples mod 2**DATA_W. After beat idx N_OUT-1, FSM enters CSUM and presents one
//    extra beat: out_data=csum, out_idx=N_OUT, out_last=1 (out_last is 0 on idx
//    N_OUT-1). frames_done increments on the CSUM beat. Frame = N_OUT+1 beats;
//    IDX_W must satisfy 2**IDX_W > N_OUT.
//  Undefined: no CSUM state, frame = N_OUT beats, out_last on idx N_OUT-1.
// TESTING
//  1 Reset: rst_n=0 mid-stream at beat 5 -> next cycle out_valid=0, in_ready=1,
//    frames_done=0, out_data=0.
//  2 Ramp y[n]=n, out_ready=1 -> beats 0,1,..,14 on consecutive cycles, out_last only
//    on idx 14, frames_done=1; with macro extra beat data=9 (105 mod 16), idx=15.
//  3 All-ones conv frame y=1,2,..,8,7,..,1, out_ready toggled 1/0 each cycle ->
//    every sample delivered once, in order, held stable during stalls.
//  4 in_valid held high while streaming frame A with frame B on y_in -> B not
//    captured until IDLE; A sent intact, then B sent; frames_done=2.
//  5 out_ready=0 for 20 cycles after load -> out_valid=1, idx=0, y[0] held; no
//    progress, in_ready=0 throughout.
//  6 256 back-to-back frames -> frames_done wraps to 0; in_ready low exactly for
//    each frame's stream cycles.

Source files
------------

// File: rtl/conv_result_serializer.sv
// conv_result_serializer
//   Captures one complete convolver result frame y[0..N_OUT-1] in a single cycle
//   and streams it out one sample per beat, index 0 first, over valid/ready.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready are
//   both 1. Once out_valid is high, out_data/out_idx/out_last hold steady until
//   the beat is accepted. in_ready depends only on the FSM state, never on in_valid.
//
//   Optional feature: define CONV_SER_CHECKSUM_EN to append one checksum beat
//   (sum of all samples mod 2**DATA_W, out_idx = N_OUT) after the last sample.
//   dbg_state exposes the FSM state (0 = IDLE, 1 = STREAM, 2 = CSUM).
module conv_result_serializer #(
   parameter int DATA_W = 4,
   parameter int N_OUT  = 15,
   parameter int IDX_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_OUT*DATA_W-1:0] y_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_last,
   output logic [7:0]              frames_done,
   output logic [1:0]              dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1
`ifdef CONV_SER_CHECKSUM_EN
      , S_CSUM = 2'd2
`endif
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] frame_q [N_OUT];
   logic [IDX_W-1:0]  idx_q;
   logic              load;
   logic              beat;
   logic              frame_end;

`ifdef CONV_SER_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;
   logic [DATA_W-1:0] sum_c;

   // Checksum of the frame currently on y_in, captured together with it on load.
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < N_OUT; i++) begin
         sum_c = sum_c + y_in[i*DATA_W +: DATA_W];
      end
   end

   // Checksum register, loaded alongside the sample buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= '0;
      end else if (load) begin
         csum_q <= sum_c;
      end
   end
`endif

   assign dbg_state = state_q;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and all handshake/data outputs, decoded from state and index.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      load      = 1'b0;
      beat      = 1'b0;
      frame_end = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_idx   = '0;
      out_last  = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            load     = in_valid;
            if (in_valid) begin
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            out_valid = 1'b1;
            out_data  = frame_q[idx_q];
            out_idx   = idx_q;
            beat      = out_ready;
`ifdef CONV_SER_CHECKSUM_EN
            // The checksum beat closes the frame, so no sample beat is last.
            out_last  = 1'b0;
            if (out_ready && (idx_q == LAST_IDX)) begin
               state_d = S_CSUM;
            end
`else
            out_last  = (idx_q == LAST_IDX);
            if (out_ready && (idx_q == LAST_IDX)) begin
               state_d   = S_IDLE;
               frame_end = 1'b1;
            end
`endif
         end
`ifdef CONV_SER_CHECKSUM_EN
         S_CSUM: begin
            out_valid = 1'b1;
            out_data  = csum_q;
            out_idx   = IDX_W'(N_OUT);
            out_last  = 1'b1;
            if (out_ready) begin
               state_d   = S_IDLE;
               frame_end = 1'b1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sample buffer: the whole frame is captured in the load cycle only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_OUT; i++) begin
            frame_q[i] <= '0;
         end
      end else if (load) begin
         for (int i = 0; i < N_OUT; i++) begin
            frame_q[i] <= y_in[i*DATA_W +: DATA_W];
         end
      end
   end

   // Read index: cleared on load, advanced on each accepted sample beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else if (load) begin
         idx_q <= '0;
      end else if (beat) begin
         idx_q <= idx_q + 1'b1;
      end
   end

   // Completed-frame counter, wraps naturally at 8 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_done <= 8'd0;
      end else if (frame_end) begin
         frames_done <= frames_done + 8'd1;
      end
   end

endmodule

// File: tb/tb_conv_result_serializer.sv
// tb_conv_result_serializer
//   Directed bench for conv_result_serializer. A queue-of-beats model predicts
//   every output each cycle; a few literal checks pin the model to hand values.
module tb_conv_result_serializer;

   localparam int DATA_W = 4;
   localparam int N_OUT  = 15;
   localparam int IDX_W  = 4;
   localparam int FW     = N_OUT * DATA_W;
`ifdef CONV_SER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif
   localparam int BEATS = N_OUT + (CSUM_EN ? 1 : 0);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [IDX_W-1:0]  idx;
      logic              last;
   } beat_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [FW-1:0]     y_in = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;
   logic              out_last;
   logic [7:0]        frames_done;
   logic [1:0]        dbg_state;

   conv_result_serializer #(.DATA_W(DATA_W), .N_OUT(N_OUT), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .y_in(y_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .frames_done(frames_done), .dbg_state(dbg_state)
   );

   // ---------------- counters ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The serializer is a single-frame holding queue: a frame is accepted only
   // when nothing is pending, and beats leave from the front on out_ready.
   beat_t      exp_q[$];
   logic [7:0] model_frames = 8'd0;
   int         model_loads  = 0;
   int         model_pops   = 0;
   int         frames_total = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         model_frames = 8'd0;
      end else if (exp_q.size() == 0) begin
         if (in_valid) begin
            logic [DATA_W-1:0] sum;
            beat_t b;
            sum = '0;
            for (int n = 0; n < N_OUT; n++) begin
               b.data = y_in[n*DATA_W +: DATA_W];
               b.idx  = IDX_W'(n);
               b.last = (n == N_OUT - 1) && !CSUM_EN;
               sum    = sum + b.data;
               exp_q.push_back(b);
            end
            if (CSUM_EN) begin
               b.data = sum;
               b.idx  = IDX_W'(N_OUT);
               b.last = 1'b1;
               exp_q.push_back(b);
            end
            model_loads++;
         end
      end else if (out_ready) begin
         beat_t f;
         f = exp_q.pop_front();
         model_pops++;
         if (f.last) begin
            model_frames = model_frames + 8'd1;
            frames_total++;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
         check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         check("frames_done", 32'(frames_done), 32'(model_frames));
         if (exp_q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(exp_q[0].data));
            check("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
            check("out_last", 32'(out_last), 32'(exp_q[0].last));
         end else begin
            check("idle_data", 32'(out_data), 32'd0);
            check("idle_idx", 32'(out_idx), 32'd0);
            check("idle_last", 32'(out_last), 32'd0);
         end
      end
   end

   // Record accepted DUT beats for the literal pins.
   logic [DATA_W-1:0] rec_q[$];
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) rec_q.push_back(out_data);
   end

   // ---------------- drivers ----------------
   int ready_mode = 0;   // 0 = always ready, 1 = toggle, 2 = stalled
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = ~out_ready;
         default: out_ready = 1'b0;
      endcase
   end

   task automatic wait_loads(input int target, input int budget);
      int k;
      k = 0;
      while (model_loads < target && k < budget) begin
         @(posedge clk); #1; k++;
      end
      check("load_timeout", 32'(model_loads >= target), 32'd1);
   endtask

   task automatic wait_frames(input int target, input int budget);
      int k;
      k = 0;
      while (frames_total < target && k < budget) begin
         @(posedge clk); #1; k++;
      end
      check("frame_timeout", 32'(frames_total >= target), 32'd1);
   endtask

   task automatic send_frame(input logic [FW-1:0] fr);
      y_in = fr;
      in_valid = 1'b1;
      wait_loads(model_loads + 1, 200);
      in_valid = 1'b0;
   endtask

   function automatic logic [FW-1:0] ramp_frame();
      logic [FW-1:0] f;
      for (int n = 0; n < N_OUT; n++) f[n*DATA_W +: DATA_W] = DATA_W'(n);
      return f;
   endfunction

   function automatic logic [FW-1:0] conv_frame();
      logic [FW-1:0] f;
      for (int n = 0; n < N_OUT; n++)
         f[n*DATA_W +: DATA_W] = DATA_W'((n < 8) ? n + 1 : 15 - n);
      return f;
   endfunction

   function automatic logic [FW-1:0] rand_frame();
      logic [FW-1:0] f;
      for (int n = 0; n < N_OUT; n++) f[n*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 15));
      return f;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int base;
      logic [7:0] fd0;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); #2;
      check("rst_frames_done", 32'(frames_done), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Ramp frame at full rate.
      ready_mode = 0;
      rec_q.delete();
      send_frame(ramp_frame());
      wait_frames(1, 100);
      @(negedge clk); #2;
      check("ramp_frames_done", 32'(frames_done), 32'd1);
      check("ramp_beats", 32'(rec_q.size()), 32'(BEATS));
      if (rec_q.size() >= N_OUT) begin
         check("ramp_first", 32'(rec_q[0]), 32'd0);
         check("ramp_y14", 32'(rec_q[14]), 32'd14);
      end
      if (CSUM_EN && rec_q.size() == N_OUT + 1) check("ramp_csum", 32'(rec_q[15]), 32'd9);

      // Stall for 20 cycles right after load.
      ready_mode = 2;
      base = frames_total;
      send_frame(conv_frame());
      repeat (20) @(negedge clk);
      #2;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_idx", 32'(out_idx), 32'd0);
      check("stall_data", 32'(out_data), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      ready_mode = 0;
      wait_frames(base + 1, 100);

      // Conv frame with out_ready toggling every cycle.
      ready_mode = 1;
      rec_q.delete();
      base = frames_total;
      send_frame(conv_frame());
      wait_frames(base + 1, 200);
      @(negedge clk); #2;
      check("toggle_beats", 32'(rec_q.size()), 32'(BEATS));
      if (rec_q.size() >= N_OUT) begin
         check("toggle_y7", 32'(rec_q[7]), 32'd8);
         check("toggle_y14", 32'(rec_q[14]), 32'd1);
      end

      // in_valid held high while A streams with B already on y_in.
      ready_mode = 0;
      base = frames_total;
      fd0 = model_frames;
      y_in = rand_frame();
      in_valid = 1'b1;
      wait_loads(model_loads + 1, 50);
      y_in = rand_frame();
      wait_loads(model_loads + 1, 50);
      in_valid = 1'b0;
      wait_frames(base + 2, 100);
      @(negedge clk); #2;
      check("ab_frames_done", 32'(frames_done), 32'(fd0 + 8'd2));

      // 256 back-to-back frames: counter wraps to its starting value.
      base = frames_total;
      fd0 = model_frames;
      in_valid = 1'b1;
      for (int f = 0; f < 256; f++) begin
         y_in = rand_frame();
         wait_loads(model_loads + 1, 50);
      end
      in_valid = 1'b0;
      wait_frames(base + 256, 100);
      @(negedge clk); #2;
      check("wrap_frames_done", 32'(frames_done), 32'(fd0));

      // Reset in the middle of a frame, at beat 5.
      ready_mode = 0;
      base = model_pops;
      y_in = ramp_frame();
      in_valid = 1'b1;
      wait_loads(model_loads + 1, 50);
      in_valid = 1'b0;
      while (model_pops < base + 5) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(negedge clk); #2;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_frames_done", 32'(frames_done), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk); #2;
      check("postrst_in_ready", 32'(in_ready), 32'd1);
      check("postrst_out_valid", 32'(out_valid), 32'd0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
